// File: rtl/ifetch_prefetch_queue_pkg.sv
// Shared widths, FSM encodings and the queue entry type for the instruction
// prefetch queue. The optional bypass path is controlled by PFQ_BYPASS_EN
// (see ifetch_prefetch_queue.sv).
package ifq_pkg;

    localparam int IFQ_WORD_W  = 32;
    localparam int IFQ_WADDR_W = 30;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    typedef struct packed {
        logic [IFQ_WADDR_W-1:0] addr;
        logic [IFQ_WORD_W-1:0]  word;
    } ifq_entry_t;

    // Word index of a byte address; the low two bits are ignored.
    function automatic logic [IFQ_WADDR_W-1:0] ifq_word_of(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/ifetch_prefetch_queue_if.sv
// I-cache request bus, redirect strobe and aligner-facing queue head.
// master: the prefetch queue. slave: the I-cache / aligner environment.
interface ifetch_prefetch_queue_if;
    import ifq_pkg::*;

    logic                   ic_read;
    logic [IFQ_WADDR_W-1:0] ic_addr;
    logic [IFQ_WORD_W-1:0]  ic_rdata;
    logic                   ic_stall;

    logic                   flush;
    logic [31:0]            flush_addr;

    logic                   q_valid;
    logic [31:0]            q_addr;
    logic [IFQ_WORD_W-1:0]  q_word;
    logic                   q_nvalid;
    logic [IFQ_WORD_W-1:0]  q_nword;
    logic                   q_pop;

    modport master (
        output ic_read, ic_addr,
        input  ic_rdata, ic_stall,
        input  flush, flush_addr,
        output q_valid, q_addr, q_word, q_nvalid, q_nword,
        input  q_pop
    );

    modport slave (
        input  ic_read, ic_addr,
        output ic_rdata, ic_stall,
        output flush, flush_addr,
        input  q_valid, q_addr, q_word, q_nvalid, q_nword,
        output q_pop
    );

endinterface

// File: rtl/ifetch_prefetch_queue_fifo.sv
// DEPTH-entry circular buffer of {word address, word} with head and head+1
// read ports. Clear wins over push/pop; pop on empty is ignored.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  ifq_entry_t                push_entry,
    input  logic                      pop,
    input  logic                      clear,
    output logic                      head_valid,
    output ifq_entry_t                head_entry,
    output logic                      next_valid,
    output ifq_entry_t                next_entry,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    ifq_entry_t      entry_q [DEPTH];
    ifq_entry_t      entry_d [DEPTH];
    logic [IW-1:0]   head_q, head_d;
    logic [IW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   next_idx;
    logic            do_push, do_pop;

    // Pointer, count and storage update for push/pop/clear.
    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != FULL_C) || do_pop);
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                entry_d[tail_q] = push_entry;
                tail_d          = tail_q + IW'(1);
            end
            if (do_pop) begin
                head_d = head_q + IW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Read ports are forced to zero when the entry is not valid.
    always_comb begin
        next_idx   = head_q + IW'(1);
        head_valid = (count_q != '0);
        next_valid = (count_q > CW'(1));
        head_entry = head_valid ? entry_q[head_q]   : '0;
        next_entry = next_valid ? entry_q[next_idx] : '0;
        count      = count_q;
    end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from the I-cache ahead
// of the compressed-instruction aligner and handles redirects. Defining
// PFQ_BYPASS_EN adds a same-cycle ic_rdata -> q_word path when the queue is
// empty.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_RUN     | normal fetch; request whenever the queue has room
//  ST_DISCARD | redirect arrived during a stalled request; hold the request,
//             | drop its data, then resume at redir_ptr
module ifetch_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    ifetch_prefetch_queue_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [0:0]             state_q, state_d;
    logic [IFQ_WADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [IFQ_WADDR_W-1:0] redir_ptr_q, redir_ptr_d;

    logic                   fifo_push, fifo_pop, fifo_clear;
    ifq_entry_t             fifo_push_entry;
    logic                   head_valid, next_valid;
    ifq_entry_t             head_entry, next_entry;
    logic [CW-1:0]          fifo_count;

    logic                   ic_read_c;
    logic                   accept;
    logic [IFQ_WADDR_W-1:0] flush_word;
    logic                   bypass_hit;
    logic                   bypass_drop;

    // Request generation; held high in DISCARD because the cache cannot abort.
    // Reset is folded in so the request drops the moment reset is asserted.
    always_comb begin
        ic_read_c   = rst && ((state_q == ST_DISCARD) || (fifo_count != FULL_C));
        accept      = ic_read_c && !bus.ic_stall;
        flush_word  = ifq_word_of(bus.flush_addr);
        bus.ic_read = ic_read_c;
        bus.ic_addr = fetch_ptr_q;
    end

`ifdef PFQ_BYPASS_EN
    // Empty-queue hit forwarded straight to the aligner; not stored if popped.
    always_comb begin
        bypass_hit  = (state_q == ST_RUN) && !bus.flush && accept && (fifo_count == '0);
        bypass_drop = bypass_hit && bus.q_pop;
    end
`else
    // No forwarding path in this build.
    always_comb begin
        bypass_hit  = 1'b0;
        bypass_drop = 1'b0;
    end
`endif

    // Redirect FSM and fetch-pointer sequencing.
    always_comb begin
        state_d         = state_q;
        fetch_ptr_d     = fetch_ptr_q;
        redir_ptr_d     = redir_ptr_q;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;
        fifo_clear      = 1'b0;
        fifo_push_entry = '{addr: fetch_ptr_q, word: bus.ic_rdata};
        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    fifo_clear = 1'b1;
                    if (ic_read_c && bus.ic_stall) begin
                        state_d     = ST_DISCARD;
                        redir_ptr_d = flush_word;
                    end else begin
                        fetch_ptr_d = flush_word;
                    end
                end else begin
                    fifo_pop  = bus.q_pop;
                    fifo_push = accept && !bypass_drop;
                    if (accept) begin
                        fetch_ptr_d = fetch_ptr_q + IFQ_WADDR_W'(1);
                    end
                end
            end
            default: begin
                if (bus.flush) begin
                    fifo_clear  = 1'b1;
                    redir_ptr_d = flush_word;
                end
                if (accept) begin
                    state_d     = ST_RUN;
                    fetch_ptr_d = bus.flush ? flush_word : redir_ptr_q;
                end
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fetch_ptr_q <= ifq_word_of(RESET_PC);
            redir_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            redir_ptr_q <= redir_ptr_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (fifo_push_entry),
        .pop        (fifo_pop),
        .clear      (fifo_clear),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .next_valid (next_valid),
        .next_entry (next_entry),
        .count      (fifo_count)
    );

    // Aligner-facing head and next word.
    always_comb begin
        bus.q_nvalid = next_valid;
        bus.q_nword  = next_entry.word;
        if (bypass_hit) begin
            bus.q_valid = 1'b1;
            bus.q_addr  = {fetch_ptr_q, 2'b00};
            bus.q_word  = bus.ic_rdata;
        end else begin
            bus.q_valid = head_valid;
            bus.q_addr  = {head_entry.addr, 2'b00};
            bus.q_word  = head_entry.word;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Randomized self-checking bench for ifetch_prefetch_queue (default build).
// The reference keeps the queue contents as a list of {address, word} and
// applies the fetch/redirect rules cycle by cycle.
module tb_ifetch_prefetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] w;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ifetch_prefetch_queue_if bus();

    ifetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.ic_rdata = mem_word(bus.ic_addr);

    // reference state
    ent_t        mq[$];
    logic [29:0] m_fetch;
    logic [29:0] m_redir;
    bit          m_disc;
    bit          hold_pend;
    logic [29:0] hold_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_read();
        return m_disc ? 1'b1 : (mq.size() < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fetch   = RESET_PC[31:2];
        m_redir   = '0;
        m_disc    = 1'b0;
        hold_pend = 1'b0;
    endtask

    task automatic check_outputs();
        bit v, nv;
        v  = (mq.size() > 0);
        nv = (mq.size() > 1);
        if (hold_pend) begin
            chk("hold_read", 32'(bus.ic_read), 32'd1);
            chk("hold_addr", 32'(bus.ic_addr), 32'(hold_addr));
        end
        chk("ic_read",  32'(bus.ic_read),  32'(exp_read()));
        chk("ic_addr",  32'(bus.ic_addr),  32'(m_fetch));
        chk("q_valid",  32'(bus.q_valid),  32'(v));
        chk("q_addr",   bus.q_addr,        v ? {mq[0].a, 2'b00} : 32'h0);
        chk("q_word",   bus.q_word,        v ? mq[0].w : 32'h0);
        chk("q_nvalid", 32'(bus.q_nvalid), 32'(nv));
        chk("q_nword",  bus.q_nword,       nv ? mq[1].w : 32'h0);
    endtask

    task automatic model_step(input bit st, input bit fl, input logic [31:0] fa, input bit pp);
        bit rd, acc;
        rd  = exp_read();
        acc = rd && !st;
        hold_pend = rd && st;
        hold_addr = m_fetch;
        if (!m_disc) begin
            if (fl) begin
                mq.delete();
                if (rd && st) begin
                    m_disc  = 1'b1;
                    m_redir = fa[31:2];
                end else begin
                    m_fetch = fa[31:2];
                end
            end else begin
                if (pp && mq.size() > 0) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back('{a: m_fetch, w: mem_word(m_fetch)});
                    m_fetch = m_fetch + 30'd1;
                end
            end
        end else begin
            if (fl) m_redir = fa[31:2];
            if (acc) begin
                m_fetch = m_redir;
                m_disc  = 1'b0;
            end
        end
    endtask

    // One clock: entered and left at negedge+1, inputs applied for the next posedge.
    task automatic cycle(input bit st, input bit fl, input logic [31:0] fa, input bit pp);
        check_outputs();
        bus.ic_stall   = st;
        bus.flush      = fl;
        bus.flush_addr = fa;
        bus.q_pop      = pp;
        model_step(st, fl, fa, pp);
        @(negedge clk);
        #1;
    endtask

    // Asynchronous reset pulse applied between clock edges.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_q_valid",  32'(bus.q_valid),  32'd0);
        chk("rst_q_nvalid", 32'(bus.q_nvalid), 32'd0);
        chk("rst_ic_read",  32'(bus.ic_read),  32'd0);
        chk("rst_ic_addr",  32'(bus.ic_addr),  32'(RESET_PC[31:2]));
        chk("rst_q_addr",   bus.q_addr,        32'h0);
        chk("rst_q_word",   bus.q_word,        32'h0);
        model_reset();
        bus.ic_stall = 1'b0;
        bus.flush    = 1'b0;
        bus.q_pop    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic run_to_word(input logic [29:0] w);
        for (int i = 0; i < 40 && m_fetch != w; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("reach_word", 32'(m_fetch), 32'(w));
    endtask

    initial begin
        bus.ic_stall   = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_addr = 32'h0;
        bus.q_pop      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        do_reset();

        // fill with no pops: four sequential requests then stop
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("full_ic_read", 32'(bus.ic_read), 32'd0);
        chk("full_q_word",  bus.q_word,  mem_word(30'd0));
        chk("full_q_nword", bus.q_nword, mem_word(30'd1));

        // pop every cycle with a three-cycle stall on word 2
        do_reset();
        for (int i = 0; i < 12; i++) cycle((m_fetch == 30'd2 && i < 5 && i >= 2), 1'b0, 32'h0, 1'b1);

        // redirect with no stalled request
        cycle(1'b0, 1'b1, 32'h0000_0106, 1'b0);
        chk("redir_ic_addr", 32'(bus.ic_addr), 32'h41);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_q_valid",  32'(bus.q_valid),  32'd1);
        chk("redir_q_addr",   bus.q_addr,        32'h104);
        chk("redir_q_nvalid", 32'(bus.q_nvalid), 32'd0);

        // redirect during a stalled request on word 5
        do_reset();
        run_to_word(30'd5);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("disc_ic_addr", 32'(bus.ic_addr), 32'd5);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("disc_resume", 32'(bus.ic_addr), 32'h80);
        chk("disc_drop",   32'(bus.q_valid), 32'd0);

        // two redirects while discarding: latest wins
        do_reset();
        run_to_word(30'd5);
        cycle(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0400, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("disc2_resume", 32'(bus.ic_addr), 32'h100);

        // fetch pointer wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_top", 32'(bus.ic_addr), 32'h3FFF_FFFF);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_zero",   32'(bus.ic_addr), 32'h0);
        chk("wrap_q_addr", bus.q_addr,       32'hFFFF_FFFC);

        // reset in the middle of a stalled request
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("post_rst_q_addr", bus.q_addr, RESET_PC);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                logic [31:0] fa;
                fa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, fa, $urandom_range(0, 9) < 6);
            end
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
